instr_loader: RTL and testbench
===============================

// Module: instr_loader
// PURPOSE
//  Program loader feeding the IF stage instruction buffer (512 x 32-bit) over its write port
//  (load_en / instr_load_addr / instruction_in). Accepts a byte stream with valid/ready handshake,
//  assembles big-endian 32-bit words, and writes them to consecutive buffer addresses from 0.
//  Holds the core in reset (core_hold) until the program, padded to an even word count, is loaded.
// PARAMETERS
//  DEPTH   512  instruction buffer depth in words
//  ADDR_W  9    buffer address width, log2(DEPTH)
// PORTS
//  clk              in   1       clock, all state on rising edge
//  rst              in   1       asynchronous reset, active-high
//  start            in   1       1-cycle pulse: begin load of word_count words (IDLE/DONE only)
//  word_count       in   10      program length in words, sampled on start; valid 1..DEPTH
//  byte_in          in   [0:7]   stream byte, bit 0 = MSB
//  byte_valid       in   1       byte_in valid
//  byte_ready       out  1       loader accepts byte; transfer when byte_valid & byte_ready
//  load_en          out  1       buffer write strobe, 1-cycle pulse per word
//  instr_load_addr  out  [0:8]   buffer write address
//  instruction_out  out  [0:31]  buffer write data (drives IF instruction_in)
//  core_hold        out  1       1 = keep core pipeline in reset/stalled
//  load_done        out  1       level: program fully written
//  load_err         out  1       level: start rejected (word_count 0 or > DEPTH)
// BEHAVIOUR
//  Reset: state IDLE; byte_ready=0, load_en=0, instr_load_addr=0, instruction_out=0,
//   core_hold=1, load_done=0, load_err=0, byte counter=0, word counter=0.
//  States: IDLE, LOAD, PAD, DONE. Reset mid-load aborts immediately; no partial-state retention.
//  IDLE/DONE + start: word_count in 1..DEPTH -> latch count, clear load_done/load_err,
//   core_hold=1, addr counter=0, byte counter=0, go LOAD. Otherwise load_err=1, go DONE, no writes,
//   load_done=0, core_hold stays 1. start in LOAD/PAD ignored.
//  LOAD: byte_ready=1. Accepted byte k (0..3) of a word goes to bits [8k:8k+7] (first byte = MSB).
//   Cycle after 4th byte accepted: load_en=1, instruction_out=assembled word,
//   instr_load_addr=word index; word index increments after the write. Byte accepts continue
//   back-to-back (one word every 4 cycles max, no bubble). byte_valid low simply pauses.
//  Last word: byte_ready drops the cycle after its 4th byte accepted (no extra bytes consumed).
//   If latched count odd and < DEPTH -> PAD: one load_en with instruction_out=0 at next address.
//   Then DONE (count even, or count == DEPTH: no pad).
//  DONE: load_done=1, core_hold=0, byte_ready=0, load_en=0; outputs addr/data hold last write.
//  Counters: word index 10 bits internally, instr_load_addr = low 9 bits; never wraps since
//   count <= DEPTH. Byte counter 2 bits, wraps 3->0 on word completion.
//  Latency: 4th-byte handshake -> load_en exactly 1 cycle later; last write -> load_done 1 cycle.
// TESTING
//  1. rst pulse mid-LOAD after 2 words -> all outputs at reset values next cycle, core_hold=1.
//  2. start, word_count=2, bytes 00 11 22 33 44 55 66 77 continuous -> load_en @addr0=0x00112233,
//     @addr1=0x44556677, no pad write, load_done=1 and core_hold=0 one cycle after 2nd write.
//  3. word_count=3, bytes valid with random gaps -> 3 data writes at 0..2, pad write 0 at addr 3,
//     then DONE; byte_ready low after 12th byte, 13th offered byte not consumed.
//  4. word_count=512 streamed back-to-back -> 512 writes, last at addr 511, no pad, load_done=1.
//  5. start with word_count=0 and with 513 -> load_err=1, zero load_en pulses, core_hold stays 1.
//  6. start asserted during LOAD -> ignored; then start from DONE with count 1 -> reload at addr 0,
//     pad at addr 1, load_done cleared during reload and re-set at end.

Source files
------------

// File: rtl/instr_loader.sv
// Program loader: turns a valid/ready byte stream into big-endian 32-bit words,
// writes them to the IF instruction buffer from address 0, pads odd-length
// programs to an even word count, and holds the core until loading completes.
module instr_loader #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [0:7]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              load_en,
  output logic [0:ADDR_W-1] instr_load_addr,
  output logic [0:31]       instruction_out,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PAD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]  count_q,    count_d;
  logic [CNT_W-1:0]  word_idx_q, word_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [0:23]       asm_q,      asm_d;

  logic              byte_ready_d;
  logic              load_en_d;
  logic [0:ADDR_W-1] addr_d;
  logic [0:31]       data_d;
  logic              core_hold_d;
  logic              load_done_d;
  logic              load_err_d;

  logic hs;
  logic count_ok;
  logic last_word;
  logic pad_need;

  assign hs        = byte_valid && byte_ready;
  assign count_ok  = (word_count != '0) && (word_count <= CNT_W'(DEPTH));
  assign last_word = (word_idx_q == (count_q - CNT_W'(1)));
  assign pad_need  = count_q[0] && (count_q < CNT_W'(DEPTH));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode; the last data write cycle is always spent in PAD so
  // load_done trails the final buffer write by exactly one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = count_ok ? LOAD : DONE;
      LOAD:       if (hs && (byte_cnt_q == 2'd3) && last_word) next_state = PAD;
      PAD:        next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  // Next values for registered outputs and datapath counters
  always_comb begin
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    load_en_d  = 1'b0;
    addr_d     = instr_load_addr;
    data_d     = instruction_out;
    load_err_d = load_err;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (count_ok) begin
            count_d    = word_count;
            word_idx_d = '0;
            byte_cnt_d = 2'd0;
            load_err_d = 1'b0;
          end else begin
            load_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (hs) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[0:7]   = byte_in;
            2'd1: asm_d[8:15]  = byte_in;
            2'd2: asm_d[16:23] = byte_in;
            default: begin
              load_en_d  = 1'b1;
              data_d     = {asm_q, byte_in};
              addr_d     = word_idx_q[ADDR_W-1:0];
              word_idx_d = word_idx_q + CNT_W'(1);
            end
          endcase
        end
      end
      PAD: begin
        if (pad_need) begin
          load_en_d  = 1'b1;
          data_d     = '0;
          addr_d     = word_idx_q[ADDR_W-1:0];
          word_idx_d = word_idx_q + CNT_W'(1);
        end
      end
      default: ;
    endcase

    byte_ready_d = (next_state == LOAD);
    load_done_d  = (next_state == DONE) && !load_err_d && !load_en_d;
    core_hold_d  = !load_done_d;
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q         <= '0;
      word_idx_q      <= '0;
      byte_cnt_q      <= 2'd0;
      asm_q           <= '0;
      byte_ready      <= 1'b0;
      load_en         <= 1'b0;
      instr_load_addr <= '0;
      instruction_out <= '0;
      core_hold       <= 1'b1;
      load_done       <= 1'b0;
      load_err        <= 1'b0;
    end else begin
      count_q         <= count_d;
      word_idx_q      <= word_idx_d;
      byte_cnt_q      <= byte_cnt_d;
      asm_q           <= asm_d;
      byte_ready      <= byte_ready_d;
      load_en         <= load_en_d;
      instr_load_addr <= addr_d;
      instruction_out <= data_d;
      core_hold       <= core_hold_d;
      load_done       <= load_done_d;
      load_err        <= load_err_d;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: byte streaming, word assembly, padding,
// error starts, reload and mid-load reset.
module tb_instr_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  word_count;
  logic [0:7]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        load_en;
  logic [0:8]  instr_load_addr;
  logic [0:31] instruction_out;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  int errors = 0;
  int checks = 0;

  bit [8:0]  wr_a[$];
  bit [31:0] wr_d[$];

  instr_loader dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .word_count      (word_count),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .load_en         (load_en),
    .instr_load_addr (instr_load_addr),
    .instruction_out (instruction_out),
    .core_hold       (core_hold),
    .load_done       (load_done),
    .load_err        (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every buffer write
  always @(negedge clk) begin
    if (load_en === 1'b1) begin
      wr_a.push_back(instr_load_addr);
      wr_d.push_back(instruction_out);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input int idx, input logic [31:0] ea, input logic [31:0] ed);
    if (idx < wr_a.size()) begin
      chk("wr_addr", 32'(wr_a[idx]), ea);
      chk("wr_data", wr_d[idx], ed);
    end else begin
      chk("wr_missing", 32'(wr_a.size()), 32'(idx + 1));
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    logic acc;
    byte_in    = b;
    byte_valid = 1'b1;
    n = 0;
    do begin
      acc = byte_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("hs_timeout", 32'(byte_ready), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [9:0] cnt);
    word_count = cnt;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_load_en"},    32'(load_en), 32'd0);
    chk({tag, "_addr"},       32'(instr_load_addr), 32'd0);
    chk({tag, "_data"},       instruction_out, 32'd0);
    chk({tag, "_core_hold"},  32'(core_hold), 32'd1);
    chk({tag, "_load_done"},  32'(load_done), 32'd0);
    chk({tag, "_load_err"},   32'(load_err), 32'd0);
  endtask

  initial begin
    int base;
    int gaps[12];
    logic [31:0] w;
    gaps = '{0, 2, 1, 0, 3, 0, 1, 2, 0, 0, 1, 0};

    rst = 1'b1; start = 1'b0; word_count = '0; byte_in = '0; byte_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("por");

    // Two words, continuous stream, no pad
    base = wr_a.size();
    pulse_start(10'd2);
    chk("t2_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(8'h11 * i));
    chk("t2_ready_drop", 32'(byte_ready), 32'd0);
    chk("t2_done_early", 32'(load_done), 32'd0);
    tick();
    chk("t2_done", 32'(load_done), 32'd1);
    chk("t2_hold", 32'(core_hold), 32'd0);
    chk("t2_addr_hold", 32'(instr_load_addr), 32'd1);
    chk("t2_data_hold", instruction_out, 32'h44556677);
    tick(); tick();
    chk("t2_nwr", 32'(wr_a.size() - base), 32'd2);
    chk_wr(base + 0, 32'd0, 32'h00112233);
    chk_wr(base + 1, 32'd1, 32'h44556677);

    // Three words with gaps, ignored start mid-load, pad, unconsumed 13th byte
    base = wr_a.size();
    pulse_start(10'd3);
    chk("t3_done_clr", 32'(load_done), 32'd0);
    chk("t3_hold", 32'(core_hold), 32'd1);
    for (int i = 0; i < 12; i++) begin
      for (int g = 0; g < gaps[i]; g++) tick();
      if (i == 5) pulse_start(10'd1);
      send_byte(8'(8'h10 + i));
    end
    byte_in = 8'hEE; byte_valid = 1'b1;
    chk("t3_ready_drop", 32'(byte_ready), 32'd0);
    tick();
    chk("t3_pad_en", 32'(load_en), 32'd1);
    chk("t3_pad_addr", 32'(instr_load_addr), 32'd3);
    chk("t3_pad_data", instruction_out, 32'd0);
    chk("t3_done_early", 32'(load_done), 32'd0);
    tick();
    chk("t3_done", 32'(load_done), 32'd1);
    chk("t3_ready_hold", 32'(byte_ready), 32'd0);
    tick(); tick();
    byte_valid = 1'b0;
    chk("t3_nwr", 32'(wr_a.size() - base), 32'd4);
    chk_wr(base + 0, 32'd0, 32'h10111213);
    chk_wr(base + 1, 32'd1, 32'h14151617);
    chk_wr(base + 2, 32'd2, 32'h18191A1B);
    chk_wr(base + 3, 32'd3, 32'h00000000);

    // Rejected starts: 0 and 513
    base = wr_a.size();
    pulse_start(10'd0);
    chk("t5a_err", 32'(load_err), 32'd1);
    chk("t5a_done", 32'(load_done), 32'd0);
    chk("t5a_hold", 32'(core_hold), 32'd1);
    chk("t5a_ready", 32'(byte_ready), 32'd0);
    tick(); tick();
    pulse_start(10'd513);
    chk("t5b_err", 32'(load_err), 32'd1);
    chk("t5b_done", 32'(load_done), 32'd0);
    chk("t5b_hold", 32'(core_hold), 32'd1);
    tick(); tick(); tick();
    chk("t5_nwr", 32'(wr_a.size() - base), 32'd0);

    // Reload from DONE with one word: data at 0, pad at 1
    base = wr_a.size();
    pulse_start(10'd1);
    chk("t6_err_clr", 32'(load_err), 32'd0);
    chk("t6_done_clr", 32'(load_done), 32'd0);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    tick(); tick();
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_hold", 32'(core_hold), 32'd0);
    chk("t6_nwr", 32'(wr_a.size() - base), 32'd2);
    chk_wr(base + 0, 32'd0, 32'hAABBCCDD);
    chk_wr(base + 1, 32'd1, 32'h00000000);

    // Full-depth program, back-to-back
    base = wr_a.size();
    pulse_start(10'd512);
    for (int i = 0; i < 512; i++) begin
      w = {8'(i >> 8), 8'(i), 8'hC3, 8'(~i)};
      send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
    end
    tick();
    chk("t4_done", 32'(load_done), 32'd1);
    chk("t4_addr_last", 32'(instr_load_addr), 32'd511);
    tick(); tick();
    chk("t4_nwr", 32'(wr_a.size() - base), 32'd512);
    for (int i = 0; i < 512; i++) begin
      w = {8'(i >> 8), 8'(i), 8'hC3, 8'(~i)};
      chk_wr(base + i, 32'(i), w);
    end

    // Reset in the middle of a load after two words
    base = wr_a.size();
    pulse_start(10'd4);
    for (int i = 0; i < 9; i++) send_byte(8'(8'h20 + i));
    chk("t1_pre_nwr", 32'(wr_a.size() - base), 32'd2);
    chk("t1_pre_hold", 32'(core_hold), 32'd1);
    rst = 1'b1;
    tick();
    chk_reset_vals("mid_rst");
    rst = 1'b0;
    tick(); tick();
    chk("t1_post_ready", 32'(byte_ready), 32'd0);
    chk("t1_post_nwr", 32'(wr_a.size() - base), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
